hilo_acc: RTL and testbench

HILO_ACC -- requirements
Module: hilo_acc

---
 rtl/hilo_pkg.sv | 25 ++
 rtl/hilo_adder.sv | 23 ++
 rtl/hilo_acc.sv | 138 +++++++++++++
 tb/tb_hilo_acc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types for the HI/LO accumulator.
//   acc_op_e  - operation code carried on md_op
//   state_e   - accumulator FSM state
//   is_acc_op - true when an md_op value starts a two-cycle accumulate
package hilo_pkg;

    typedef enum logic [1:0] {
        ACC_WR  = 2'b00,
        ACC_ADD = 2'b01,
        ACC_SUB = 2'b10,
        ACC_RSV = 2'b11
    } acc_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACC_LO = 2'b01,
        ACC_HI = 2'b10
    } state_e;

    // With subtract disabled, ACC_SUB falls back to a plain write.
    function automatic logic is_acc_op(input acc_op_e op, input logic sub_en);
        return (op == ACC_ADD) || ((op == ACC_SUB) && sub_en);
    endfunction

endpackage

// File: rtl/hilo_adder.sv
// hilo_adder: DATA_W-bit ripple adder with carry in/out, shared by the
// low-half and high-half accumulate steps.
//   a, b  - addends
//   cin   - carry in
//   sum   - a + b + cin (mod 2^DATA_W)
//   cout  - carry out of the top bit
module hilo_adder #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign sum      = full_sum[DATA_W-1:0];
    assign cout     = full_sum[DATA_W];

endmodule

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO register pair with multiply/divide write-back and a
// two-cycle add/subtract accumulate (low half first, then high half with
// the registered carry).
//   clk, rst           - clock, asynchronous active-low reset
//   md_valid/md_op     - result pulse and operation (write/add/sub)
//   md_hi/md_lo        - result halves
//   hi_wr/lo_wr/data_wr- MTHI/MTLO direct writes (lower priority than md_valid)
//   busy               - high while an accumulate is in flight
//   acc_done           - one-cycle pulse, the cycle the accumulated HI is visible
//   hi/lo              - committed registers
module hilo_acc
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SUB_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              md_valid,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] md_hi,
    input  logic [DATA_W-1:0] md_lo,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [DATA_W-1:0] data_wr,
    output logic              busy,
    output logic              acc_done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic SUB_OK = (SUB_EN != 0);

    state_e            state_reg, state_next;
    logic [DATA_W-1:0] hi_reg, hi_next;
    logic [DATA_W-1:0] lo_reg, lo_next;
    logic [DATA_W-1:0] op_hi_reg, op_hi_next;
    logic [DATA_W-1:0] op_lo_reg, op_lo_next;
    logic              cin_reg, cin_next;
    logic              carry_reg, carry_next;
    logic              acc_done_reg, acc_done_next;

    acc_op_e           op_in;
    logic [DATA_W-1:0] add_a, add_b, add_sum;
    logic              add_cin, add_cout;

    assign op_in = acc_op_e'(md_op);

    // The single adder is steered by state: LO step uses the captured
    // carry-in, HI step uses the carry produced by the LO step.
    assign add_a   = (state_reg == ACC_HI) ? hi_reg    : lo_reg;
    assign add_b   = (state_reg == ACC_HI) ? op_hi_reg : op_lo_reg;
    assign add_cin = (state_reg == ACC_HI) ? carry_reg : cin_reg;

    hilo_adder #(.DATA_W(DATA_W)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_next    = state_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        op_hi_next    = op_hi_reg;
        op_lo_next    = op_lo_reg;
        cin_next      = cin_reg;
        carry_next    = carry_reg;
        acc_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (md_valid) begin
                    if (is_acc_op(op_in, SUB_OK)) begin
                        // Subtract is add of the one's complement plus one.
                        if (op_in == ACC_SUB) begin
                            op_hi_next = ~md_hi;
                            op_lo_next = ~md_lo;
                            cin_next   = 1'b1;
                        end else begin
                            op_hi_next = md_hi;
                            op_lo_next = md_lo;
                            cin_next   = 1'b0;
                        end
                        state_next = ACC_LO;
                    end else begin
                        hi_next = md_hi;
                        lo_next = md_lo;
                    end
                end else begin
                    if (hi_wr) hi_next = data_wr;
                    if (lo_wr) lo_next = data_wr;
                end
            end
            ACC_LO: begin
                lo_next    = add_sum;
                carry_next = add_cout;
                state_next = ACC_HI;
            end
            ACC_HI: begin
                hi_next       = add_sum;
                acc_done_next = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            op_hi_reg    <= '0;
            op_lo_reg    <= '0;
            cin_reg      <= 1'b0;
            carry_reg    <= 1'b0;
            acc_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            op_hi_reg    <= op_hi_next;
            op_lo_reg    <= op_lo_next;
            cin_reg      <= cin_next;
            carry_reg    <= carry_next;
            acc_done_reg <= acc_done_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign acc_done = acc_done_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_hilo_acc.sv
module tb_hilo_acc;
    import hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         md_valid;
    logic [1:0]   md_op;
    logic [W-1:0] md_hi, md_lo, data_wr;
    logic         hi_wr, lo_wr;
    logic         busy, acc_done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    always #5 clk = ~clk;

    hilo_acc #(.DATA_W(W), .SUB_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_valid (md_valid),
        .md_op    (md_op),
        .md_hi    (md_hi),
        .md_lo    (md_lo),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .data_wr  (data_wr),
        .busy     (busy),
        .acc_done (acc_done),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Direct write-back (WR or reserved op), visible right after the edge.
    task automatic md_write(input logic [1:0] op, input logic [W-1:0] h, input logic [W-1:0] l);
        md_valid = 1'b1; md_op = op; md_hi = h; md_lo = l;
        step();
        md_valid = 1'b0;
        $display("md_write op=%0d hi:lo=%08h:%08h", op, h, l);
    endtask

    // Accumulate; expected result goes to the scoreboard, the monitor checks
    // it on acc_done. Optionally hammers the inputs while busy.
    task automatic acc(input logic [1:0] op, input logic [W-1:0] h, input logic [W-1:0] l,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic inject);
        exp_q.push_back({eh, el});
        md_valid = 1'b1; md_op = op; md_hi = h; md_lo = l;
        step();
        md_valid = 1'b0;
        if (inject) begin
            hi_wr = 1'b1; lo_wr = 1'b1; data_wr = 32'hAAAAAAAA;
            md_valid = 1'b1; md_op = ACC_WR; md_hi = 32'hDEADBEEF; md_lo = 32'hDEADBEEF;
        end
        @(negedge clk);
        check_bit("busy_acc_lo", busy, 1'b1);
        step();
        @(negedge clk);
        check_bit("busy_acc_hi", busy, 1'b1);
        check("lo_after_lo_step", lo, el);
        step();
        hi_wr = 1'b0; lo_wr = 1'b0; md_valid = 1'b0;
        @(negedge clk);
        check_bit("busy_after_acc", busy, 1'b0);
        step();
        $display("acc op=%0d operand=%08h:%08h expect=%08h:%08h", op, h, l, eh, el);
    endtask

    // Scoreboard monitor: every acc_done must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && acc_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL acc_done_unexpected: got hi:lo=%08h:%08h expected no pulse", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({hi, lo} !== mon_exp) begin
                    errors++;
                    $display("FAIL acc_result: got %016h expected %016h", {hi, lo}, mon_exp);
                end else begin
                    $display("acc_done hi:lo=%08h:%08h", hi, lo);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; md_valid = 1'b0; md_op = 2'b00; md_hi = '0; md_lo = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; data_wr = '0;
        step(); step();
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_acc_done", acc_done, 1'b0);
        step();
        rst = 1'b1;
        step();

        // Carry propagation from LO into HI
        md_write(ACC_WR, 32'h0, 32'hFFFFFFFF);
        check("preload_hi", hi, 32'h0);
        check("preload_lo", lo, 32'hFFFFFFFF);
        acc(ACC_ADD, 32'h0, 32'h1, 32'h00000001, 32'h00000000, 1'b0);

        // Subtract from zero
        md_write(ACC_WR, 32'h0, 32'h0);
        acc(ACC_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        // 64-bit wrap-around
        md_write(ACC_WR, 32'hFFFFFFFF, 32'hFFFFFFFF);
        acc(ACC_ADD, 32'h0, 32'h1, 32'h00000000, 32'h00000000, 1'b0);

        // Mixed add: 1_80000000 + 2_80000000 = 4_00000000
        md_write(ACC_WR, 32'h1, 32'h80000000);
        acc(ACC_ADD, 32'h2, 32'h80000000, 32'h00000004, 32'h00000000, 1'b0);

        // md_valid beats hi_wr in the same cycle
        hi_wr = 1'b1; data_wr = 32'h55555555;
        md_write(ACC_WR, 32'h12345678, 32'h9ABCDEF0);
        hi_wr = 1'b0;
        check("prio_hi", hi, 32'h12345678);
        check("prio_lo", lo, 32'h9ABCDEF0);

        // MTHI+MTLO together, then MTHI alone
        hi_wr = 1'b1; lo_wr = 1'b1; data_wr = 32'h11223344;
        step();
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthilo_hi", hi, 32'h11223344);
        check("mthilo_lo", lo, 32'h11223344);
        hi_wr = 1'b1; data_wr = 32'hCAFEBABE;
        step();
        hi_wr = 1'b0;
        check("mthi_hi", hi, 32'hCAFEBABE);
        check("mthi_lo_kept", lo, 32'h11223344);
        $display("mthi/mtlo writes done");

        // Reserved op code behaves as a write
        md_write(ACC_RSV, 32'h0BADF00D, 32'h600DCAFE);
        check("rsv_hi", hi, 32'h0BADF00D);
        check("rsv_lo", lo, 32'h600DCAFE);

        // Inputs ignored while busy
        md_write(ACC_WR, 32'h10, 32'h20);
        acc(ACC_ADD, 32'h1, 32'h2, 32'h00000011, 32'h00000022, 1'b1);

        // Reset in the middle of an accumulate (no scoreboard entry)
        md_write(ACC_WR, 32'h5, 32'h6);
        md_valid = 1'b1; md_op = ACC_ADD; md_hi = 32'h1; md_lo = 32'h1;
        step();
        md_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_acc_done", acc_done, 1'b0);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("postrst_acc_done", acc_done, 1'b0);
            check_bit("postrst_busy", busy, 1'b0);
            step();
        end
        $display("mid-accumulate reset done");

        // Normal operation resumes from the cleared state
        acc(ACC_ADD, 32'h0, 32'h7, 32'h00000000, 32'h00000007, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
